// File: rtl/seq_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : seq_adder_subtractor
// Purpose  : Digit-serial two's-complement adder/subtractor. Each clock it
//            handles DIGIT bits of the WIDTH-bit operands, least significant
//            slice first. The result and its status flags are registered and
//            change only when an operation completes.
// Ports    : CLK    - system clock, rising edge
//            RST_N  - asynchronous active-low reset
//            Start  - request, sampled only while Busy = 0
//            Mode   - 0 = A + B, 1 = A - B (sampled with Start)
//            A, B   - operands (sampled with Start)
//            S      - result register (modulo 2^WIDTH)
//            Cout   - carry out of MSB (subtract: 1 = no borrow)
//            Ovf    - signed overflow (carry into MSB ^ carry out of MSB)
//            Zero   - S == 0
//            Busy   - operation in progress
//            Done   - one-cycle pulse when S and flags are updated
// Params   : WIDTH  - operand/result width, must be a multiple of DIGIT
//            DIGIT  - bits per step; DIGIT = WIDTH gives one-step operation
// Revision : 1.0 - initial release
// ============================================================================
module seq_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic             Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int c_steps = WIDTH / DIGIT;
  localparam int c_idx_w = (c_steps > 1) ? $clog2(c_steps) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_steps - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched operation and running state
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_mode;
  logic               r_carry;
  logic [c_idx_w-1:0] r_idx;
  logic [WIDTH-1:0]   r_acc;

  // Current-slice arithmetic
  logic [DIGIT-1:0]   w_a_slice;
  logic [DIGIT-1:0]   w_b_slice;
  logic [DIGIT:0]     w_sum;
  logic               w_msb_cin;
  logic               w_last;
  logic [WIDTH-1:0]   w_acc_next;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Busy
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    Busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (w_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Slice adder. Subtraction inverts B and seeds the carry with 1, so the
  // same adder serves both modes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_last     = (r_idx == c_last_idx);
    w_a_slice  = r_a[r_idx*DIGIT +: DIGIT];
    w_b_slice  = r_b[r_idx*DIGIT +: DIGIT] ^ {DIGIT{r_mode}};
    w_sum      = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{DIGIT{1'b0}}, r_carry};
    // Carry into the slice's top bit recovered from its sum bit; on the final
    // slice this is the carry into bit WIDTH-1.
    w_msb_cin  = w_a_slice[DIGIT-1] ^ w_b_slice[DIGIT-1] ^ w_sum[DIGIT-1];
    w_acc_next = r_acc;
    w_acc_next[r_idx*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
      Zero    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_a     <= A;
            r_b     <= B;
            r_mode  <= Mode;
            r_carry <= Mode;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_sum[DIGIT];
          r_idx   <= r_idx + c_idx_w'(1);
          if (w_last) begin
            r_idx <= '0;
            S     <= w_acc_next;
            Cout  <= w_sum[DIGIT];
            Ovf   <= w_msb_cin ^ w_sum[DIGIT];
            Zero  <= (w_acc_next == '0);
            Done  <= 1'b1;
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_adder_subtractor
// Purpose  : Directed self-checking bench for seq_adder_subtractor, covering a
//            16-bit/4-bit-digit instance and a 4-bit/1-bit-digit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_adder_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16-bit, 4-bit digit instance
  logic        start, mode;
  logic [15:0] a, b, s;
  logic        cout, ovf, zero, busy, done;

  // 4-bit, 1-bit digit instance
  logic        start4, mode4;
  logic [3:0]  a4, b4, s4;
  logic        cout4, ovf4, zero4, busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;

  seq_adder_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .CLK(clk), .RST_N(rst_n), .Start(start), .Mode(mode), .A(a), .B(b),
    .S(s), .Cout(cout), .Ovf(ovf), .Zero(zero), .Busy(busy), .Done(done)
  );

  seq_adder_subtractor #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .Start(start4), .Mode(mode4), .A(a4), .B(b4),
    .S(s4), .Cout(cout4), .Ovf(ovf4), .Zero(zero4), .Busy(busy4), .Done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; returns #1 after the cycle following Done.
  task automatic op16(input string tag, input logic m, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    start = 1'b1; mode = m; a = av; b = bv;
    tick();
    start = 1'b0; mode = ~m; a = ~av; b = ~bv;   // operands must already be latched
    check({tag, ".busy0"}, busy, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, ".busy"}, busy, 1);
      check({tag, ".done_early"}, done, 0);
    end
    tick();
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".S"}, s, es);
    check({tag, ".Cout"}, cout, ec);
    check({tag, ".Ovf"}, ovf, eo);
    check({tag, ".Zero"}, zero, ez);
    tick();
    check({tag, ".done_pulse"}, done, 0);
  endtask

  task automatic op4(input string tag, input logic m, input logic [3:0] av, input logic [3:0] bv,
                     input logic [3:0] es, input logic ec, input logic eo, input logic ez);
    start4 = 1'b1; mode4 = m; a4 = av; b4 = bv;
    tick();
    start4 = 1'b0; mode4 = ~m; a4 = ~av; b4 = ~bv;
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, ".done_early"}, done4, 0);
    end
    tick();
    check({tag, ".done"}, done4, 1);
    check({tag, ".S"}, s4, es);
    check({tag, ".Cout"}, cout4, ec);
    check({tag, ".Ovf"}, ovf4, eo);
    check({tag, ".Zero"}, zero4, ez);
    tick();
    check({tag, ".done_pulse"}, done4, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; a = '0; b = '0;
    start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) tick();
    check("rst.S", s, 0);
    check("rst.flags", {cout, ovf, zero, busy, done}, 0);
    check("rst4.all", {s4, cout4, ovf4, zero4, busy4, done4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    op16("add",      1'b0, 16'h1234, 16'h0FF0, 16'h2224, 1'b0, 1'b0, 1'b0);
    op16("sub_pos",  1'b1, 16'h0008, 16'h0002, 16'h0006, 1'b1, 1'b0, 1'b0);
    op16("sub_neg",  1'b1, 16'h0002, 16'h0008, 16'hFFFA, 1'b0, 1'b0, 1'b0);
    op16("ovf_add",  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    op16("sub_zero", 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1);
    op16("wrap_add", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Start during RUN is ignored and not queued
    start = 1'b1; mode = 1'b0; a = 16'h1111; b = 16'h2222;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; mode = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    tick();
    start = 1'b0;
    check("ign.busy", busy, 1);
    tick();
    check("ign.done_early", done, 0);
    tick();
    check("ign.done", done, 1);
    check("ign.S", s, 16'h3333);
    check("ign.Cout", cout, 0);
    tick();
    check("ign.no_queue", {busy, done}, 0);

    // Back-to-back: Start in the Done cycle
    start = 1'b1; mode = 1'b0; a = 16'h0100; b = 16'h0200;
    tick();
    start = 1'b0;
    repeat (3) tick();
    tick();
    check("b2b.done1", done, 1);
    check("b2b.S1", s, 16'h0300);
    start = 1'b1; mode = 1'b1; a = 16'h0005; b = 16'h0003;
    tick();
    start = 1'b0;
    check("b2b.busy", busy, 1);
    check("b2b.hold", s, 16'h0300);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("b2b.done_early", done, 0);
    end
    tick();
    check("b2b.done2", done, 1);
    check("b2b.S2", s, 16'h0002);
    check("b2b.Cout2", cout, 1);
    tick();

    // Reset in the middle of RUN
    start = 1'b1; mode = 1'b0; a = 16'h00FF; b = 16'h0001;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst.S", s, 0);
    check("midrst.flags", {cout, ovf, zero, busy, done}, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("midrst.no_done", seen_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst.idle", busy, 0);
    op16("post_rst", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

    // 4-bit, 1-bit digit instance
    op4("sub4", 1'b1, 4'b1000, 4'b0010, 4'b0110, 1'b1, 1'b1, 1'b0);
    op4("add4", 1'b0, 4'b1110, 4'b1111, 4'b1101, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
